// File: rtl/jbi_timeout_rptr.sv
// jbi_timeout_rptr
// Collects the level error outputs of the per-JID read timeout timers. It
// detects each new timeout and queues it in a pending vector. It then presents
// pending timeouts one at a time, in round-robin order, to the error-logging
// logic over a valid/ack handshake. It also keeps a saturating event count.
//
// Ports:
//   clk            clock
//   rst_l          asynchronous active-low reset
//   tmr_error      level error per timer, bit i = JID i
//   csr_timeout_en enables capture (pend set and counting) of new timeouts
//   csr_cnt_clr    single-cycle pulse clearing err_cnt
//   rpt_vld        a timeout report is presented
//   rpt_jid        JID of the presented report
//   rpt_multi      other timeouts were pending when this report was granted
//   rpt_ack        consumer accepts the presented report
//   pend_any       registered OR of the pending vector
//   err_cnt        saturating count of accepted timeout events
module jbi_timeout_rptr #(
    parameter int NUM_TIMERS = 32,
    parameter int ID_W       = 5,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_l,
    input  logic [NUM_TIMERS-1:0] tmr_error,
    input  logic                  csr_timeout_en,
    input  logic                  csr_cnt_clr,
    output logic                  rpt_vld,
    output logic [ID_W-1:0]       rpt_jid,
    output logic                  rpt_multi,
    input  logic                  rpt_ack,
    output logic                  pend_any,
    output logic [CNT_W-1:0]      err_cnt
);

    localparam int PC_W  = $clog2(NUM_TIMERS + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ID_W:0]    NUM_T   = (ID_W+1)'(NUM_TIMERS);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_TIMERS - 1);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PRESENT = 1'b1;

    logic [NUM_TIMERS-1:0] err_q;
    logic [NUM_TIMERS-1:0] pend;
    logic [NUM_TIMERS-1:0] rise;
    logic [NUM_TIMERS-1:0] pend_masked;
    logic [NUM_TIMERS-1:0] clr_vec;
    logic [NUM_TIMERS-1:0] pend_nxt;
    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       gnt_idx;
    logic [ID_W:0]         srch;
    logic                  gnt_found;
    logic [0:0]            state;
    logic [CNT_W-1:0]      cnt_nxt;

    function automatic logic [PC_W-1:0] popcount(input logic [NUM_TIMERS-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

    // Saturating add: the counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [PC_W-1:0]  b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (s > SUM_W'(CNT_MAX)) begin
            return CNT_MAX;
        end
        return s[CNT_W-1:0];
    endfunction

    assign rise    = tmr_error & ~err_q;
    assign rpt_vld = (state == ST_PRESENT);

    // Round-robin search from rr_ptr upward with wrap. The loop walks the
    // offsets from the highest down, so the nearest pending bit wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        srch      = '0;
        for (int k = NUM_TIMERS - 1; k >= 0; k--) begin
            srch = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (srch >= NUM_T) begin
                srch = srch - NUM_T;
            end
            if (pend[srch[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = srch[ID_W-1:0];
            end
        end
    end

    always_comb begin
        pend_masked          = pend;
        pend_masked[gnt_idx] = 1'b0;
    end

    // A new rise on the bit being acked in the same cycle survives the clear.
    always_comb begin
        clr_vec = '0;
        if (state == ST_PRESENT && rpt_ack) begin
            clr_vec[rpt_jid] = 1'b1;
        end
        pend_nxt = (pend & ~clr_vec) | (rise & {NUM_TIMERS{csr_timeout_en}});
    end

    always_comb begin
        cnt_nxt = err_cnt;
        if (csr_cnt_clr) begin
            cnt_nxt = '0;
        end else if (csr_timeout_en) begin
            cnt_nxt = sat_add(err_cnt, popcount(rise));
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            err_q     <= '0;
            pend      <= '0;
            pend_any  <= 1'b0;
            err_cnt   <= '0;
            rr_ptr    <= '0;
            rpt_jid   <= '0;
            rpt_multi <= 1'b0;
            state     <= ST_IDLE;
        end else begin
            err_q    <= tmr_error;
            pend     <= pend_nxt;
            pend_any <= |pend;
            err_cnt  <= cnt_nxt;
            case (state)
                ST_IDLE: begin
                    if (gnt_found) begin
                        rpt_jid   <= gnt_idx;
                        rpt_multi <= |pend_masked;
                        state     <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (rpt_ack) begin
                        rr_ptr <= (rpt_jid == LAST_ID) ? '0 : rpt_jid + 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_jid_range : assert property (@(posedge clk) disable iff (!rst_l)
        {1'b0, rpt_jid} < NUM_T)
        else $error("rpt_jid out of range");

    a_rpt_stable : assert property (@(posedge clk) disable iff (!rst_l)
        (rpt_vld && !rpt_ack) |=> ($stable(rpt_jid) && $stable(rpt_multi)))
        else $error("report changed while stalled");
`endif

endmodule

// File: tb/tb_jbi_timeout_rptr.sv
module tb_jbi_timeout_rptr;

    localparam int N     = 32;
    localparam int ID_W  = 5;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_l;
    logic [N-1:0]     tmr_error;
    logic             csr_timeout_en;
    logic             csr_cnt_clr;
    logic             rpt_vld;
    logic [ID_W-1:0]  rpt_jid;
    logic             rpt_multi;
    logic             rpt_ack;
    logic             pend_any;
    logic [CNT_W-1:0] err_cnt;

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit [N-1:0] m_err;
    bit [N-1:0] m_pend;
    int         m_rr;
    int         m_jid;
    bit         m_multi;
    bit         m_present;
    bit         m_pend_any;
    int         m_cnt;

    jbi_timeout_rptr #(.NUM_TIMERS(N), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst_l(rst_l),
        .tmr_error(tmr_error),
        .csr_timeout_en(csr_timeout_en),
        .csr_cnt_clr(csr_cnt_clr),
        .rpt_vld(rpt_vld),
        .rpt_jid(rpt_jid),
        .rpt_multi(rpt_multi),
        .rpt_ack(rpt_ack),
        .pend_any(pend_any),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_err = '0; m_pend = '0; m_rr = 0; m_jid = 0;
        m_multi = 1'b0; m_present = 1'b0; m_pend_any = 1'b0; m_cnt = 0;
    endtask

    // One clock: apply the rules at the active edge, compare at the falling edge.
    task automatic step();
        bit [N-1:0] rise;
        bit [N-1:0] others;
        bit         found;
        int         idx;
        @(posedge clk);
        if (!rst_l) begin
            model_reset();
        end else begin
            rise       = tmr_error & ~m_err;
            m_pend_any = (m_pend != 0);
            if (!m_present) begin
                found = 1'b0;
                for (int k = 0; k < N && !found; k++) begin
                    idx = (m_rr + k) % N;
                    if (m_pend[idx]) begin
                        found = 1'b1;
                        m_jid = idx;
                    end
                end
                if (found) begin
                    others        = m_pend;
                    others[m_jid] = 1'b0;
                    m_multi       = (others != 0);
                    m_present     = 1'b1;
                end
            end else if (rpt_ack) begin
                m_pend[m_jid] = 1'b0;
                m_rr          = (m_jid + 1) % N;
                m_present     = 1'b0;
            end
            if (csr_timeout_en) m_pend |= rise;
            if (csr_cnt_clr) m_cnt = 0;
            else if (csr_timeout_en) begin
                m_cnt = m_cnt + $countones(rise);
                if (m_cnt > CMAX) m_cnt = CMAX;
            end
            m_err = tmr_error;
        end
        @(negedge clk);
        chk("rpt_vld", 32'(rpt_vld), 32'(m_present));
        chk("pend_any", 32'(pend_any), 32'(m_pend_any));
        chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
        if (m_present) begin
            chk("rpt_jid", 32'(rpt_jid), 32'(m_jid));
            chk("rpt_multi", 32'(rpt_multi), 32'(m_multi));
        end
    endtask

    // Reset asserted between edges; outputs must clear before the next edge.
    task automatic async_reset();
        #2 rst_l = 1'b0;
        #1;
        chk("arst_vld", 32'(rpt_vld), 0);
        chk("arst_pend_any", 32'(pend_any), 0);
        chk("arst_cnt", 32'(err_cnt), 0);
        chk("arst_jid", 32'(rpt_jid), 0);
        chk("arst_multi", 32'(rpt_multi), 0);
        model_reset();
        step();
        rst_l = 1'b1;
    endtask

    // Wait for a report, check it against fixed values, then ack it.
    task automatic take_report(input int exp_jid, input bit exp_multi);
        bit seen = 1'b0;
        rpt_ack = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            seen = rpt_vld;
        end
        chk("rpt_seen", 32'(seen), 1);
        if (seen) begin
            chk("dir_jid", 32'(rpt_jid), 32'(exp_jid));
            chk("dir_multi", 32'(rpt_multi), 32'(exp_multi));
            rpt_ack = 1'b1;
            step();
            rpt_ack = 1'b0;
            chk("gap_after_ack", 32'(rpt_vld), 0);
        end
    endtask

    initial begin
        rst_l = 1'b0;
        tmr_error = '0;
        csr_timeout_en = 1'b1;
        csr_cnt_clr = 1'b0;
        rpt_ack = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_vld", 32'(rpt_vld), 0);
        chk("rst_jid", 32'(rpt_jid), 0);
        chk("rst_multi", 32'(rpt_multi), 0);
        chk("rst_pend_any", 32'(pend_any), 0);
        chk("rst_cnt", 32'(err_cnt), 0);
        rst_l = 1'b1;
        step();

        // Single timeout on JID 7, reported once while held high
        tmr_error[7] = 1'b1;
        step();
        chk("e0_no_vld", 32'(rpt_vld), 0);
        take_report(7, 1'b0);
        chk("single_cnt", 32'(err_cnt), 1);
        repeat (5) step();
        chk("no_rereport", 32'(rpt_vld), 0);

        // Simultaneous rises 3, 9, 30 from a fresh rr_ptr of 0
        tmr_error = '0;
        step();
        async_reset();
        tmr_error = (N'(1) << 3) | (N'(1) << 9) | (N'(1) << 30);
        step();
        chk("simul_cnt", 32'(err_cnt), 3);
        take_report(3, 1'b1);
        take_report(9, 1'b1);
        take_report(30, 1'b0);

        // Round-robin wrap: rr_ptr now 31
        tmr_error[31] = 1'b1;
        tmr_error[0]  = 1'b1;
        take_report(31, 1'b1);
        take_report(0, 1'b0);

        // Stall with re-trigger of JID 5 coinciding with the ack
        tmr_error = '0;
        step();
        async_reset();
        tmr_error[5] = 1'b1;
        for (int i = 0; i < 20 && !rpt_vld; i++) step();
        chk("stall_vld", 32'(rpt_vld), 1);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) tmr_error[5] = 1'b0;
            step();
            chk("stall_jid", 32'(rpt_jid), 5);
            chk("stall_multi", 32'(rpt_multi), 0);
        end
        tmr_error[5] = 1'b1;
        rpt_ack = 1'b1;
        step();
        rpt_ack = 1'b0;
        take_report(5, 1'b0);

        // Enable off: no pend, no count
        csr_timeout_en = 1'b0;
        tmr_error[2] = 1'b1;
        repeat (4) step();
        chk("dis_pend_any", 32'(pend_any), 0);
        chk("dis_vld", 32'(rpt_vld), 0);
        csr_timeout_en = 1'b1;

        // Saturation: build up to 254, then overflow attempts
        rpt_ack = 1'b1;
        tmr_error = '0;
        csr_cnt_clr = 1'b1;
        step();
        csr_cnt_clr = 1'b0;
        for (int r = 0; r < 7; r++) begin
            tmr_error = '1;
            step();
            tmr_error = '0;
            step();
        end
        tmr_error = 32'h3FFF_FFFF;
        step();
        chk("cnt_254", 32'(err_cnt), 254);
        tmr_error = '0;
        step();
        tmr_error = 32'h0000_000F;
        step();
        chk("cnt_sat", 32'(err_cnt), 255);
        tmr_error = 32'h0000_00F0;
        step();
        chk("cnt_sat_hold", 32'(err_cnt), 255);
        tmr_error = 32'h0000_0F00;
        csr_cnt_clr = 1'b1;
        step();
        csr_cnt_clr = 1'b0;
        chk("cnt_clr_wins", 32'(err_cnt), 0);
        repeat (80) step();
        rpt_ack = 1'b0;

        // Async reset mid-PRESENT, then re-detection of a held bit
        tmr_error = '0;
        step();
        tmr_error[12] = 1'b1;
        for (int i = 0; i < 20 && !rpt_vld; i++) step();
        chk("pre_arst_vld", 32'(rpt_vld), 1);
        async_reset();
        take_report(12, 1'b0);
        chk("redetect_cnt", 32'(err_cnt), 1);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            tmr_error      = tmr_error ^ N'($urandom & $urandom & $urandom & $urandom);
            csr_timeout_en = ($urandom_range(0, 7) != 0);
            csr_cnt_clr    = ($urandom_range(0, 49) == 0);
            rpt_ack        = m_present ? ($urandom_range(0, 2) != 0)
                                       : ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 399) == 0) async_reset();
            else step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jbi_timeout_rptr.md
Name: jbi_timeout_rptr

Overview:
- Sits directly downstream of the per-JID timeout timers inside the non-cacheable read timeout path.
- Collects the level `error` outputs of all timer instances and detects each new timeout.
- Queues pending timeouts and presents them one at a time, with the offending JID, to the error-logging/CSR logic over a valid/ack handshake.
- Keeps a saturating count of timeout events for CSR readback.

Parameters:
- NUM_TIMERS, 32, number of timer instances (one per JID); any value >= 2.
- ID_W, 5, JID width; must satisfy 2**ID_W >= NUM_TIMERS.
- CNT_W, 8, width of the saturating timeout event counter.

Ports:
- clk  input  1  clock.
- rst_l  input  1  reset; asynchronous, active-low.
- tmr_error  input  NUM_TIMERS  level error from each timer; bit i = JID i. Stays high until that timer is stopped and cleared.
- csr_timeout_en  input  1  enables capture of new timeouts.
- csr_cnt_clr  input  1  single-cycle pulse that clears err_cnt.
- rpt_vld  output  1  a timeout report is presented.
- rpt_jid  output  ID_W  JID of the presented report.
- rpt_multi  output  1  other timeouts were still pending when this report was granted.
- rpt_ack  input  1  consumer accepts the report; meaningful only while rpt_vld=1.
- pend_any  output  1  OR of the pending vector (status/interrupt).
- err_cnt  output  CNT_W  saturating count of accepted timeout events.

Behaviour:
- Reset values: rpt_vld=0, rpt_jid=0, rpt_multi=0, pend_any=0, err_cnt=0. Internally err_q=0, pend=0, rr_ptr=0, FSM=IDLE.
- Edge detect:
  - err_q registers tmr_error every cycle.
  - rise = tmr_error & ~err_q. A bit held high is reported only once.
  - After reset, a tmr_error bit already high counts as a rise on the first cycle.
- Pending vector:
  - At each edge, pend[i] is set when rise[i] & csr_timeout_en.
  - pend[i] is cleared when the report for JID i is acked.
  - A set and a clear on the same bit in the same cycle: set wins.
  - csr_timeout_en=0 blocks new sets and counts only. Already-pending bits still drain.
- FSM, two states:
  - IDLE: if pend != 0, grant the first set bit at or above rr_ptr, searching upward and wrapping from NUM_TIMERS-1 to 0. Register rpt_jid = granted index and rpt_multi = (pend with the granted bit masked) != 0, then go to PRESENT. Otherwise stay in IDLE.
  - PRESENT: rpt_vld=1; rpt_jid and rpt_multi are held stable.
    - rpt_ack=1: clear pend[rpt_jid], set rr_ptr = rpt_jid+1 (wrapping NUM_TIMERS-1 -> 0), go to IDLE. rpt_vld drops at that edge.
    - rpt_ack=0: stay in PRESENT.
  - rpt_ack in IDLE is ignored.
- Latency:
  - tmr_error rises before edge E0 -> pend set at E0 -> grant at E1 -> rpt_vld high after E1.
  - Back-to-back reports have at least one IDLE cycle between them (rpt_vld low for >= 1 cycle).
- pend_any is registered: equals |pend, one cycle behind pend.
- err_cnt:
  - Each cycle, err_cnt += popcount(rise) when csr_timeout_en=1.
  - Saturates at 2**CNT_W-1; never wraps.
  - csr_cnt_clr sets err_cnt to 0 and discards increments in the same cycle.
- tmr_error falling while its bit is pending or presented has no effect; the report still completes.
- Reset asserted mid-handshake returns all state to reset values immediately (asynchronous); pending reports are lost.
- Monitors (translate_off):
  - Flag rpt_jid >= NUM_TIMERS.
  - Flag rpt_jid or rpt_multi changing while rpt_vld=1 and rpt_ack=0.

Test Plan:
- Single timeout: en=1, tmr_error[7] rises at E0 -> rpt_vld high after E1 with rpt_jid=7, rpt_multi=0, err_cnt=1. Ack -> rpt_vld low; no second report while bit 7 stays high.
- Simultaneous rises: bits 3, 9 and 30 rise in one cycle -> err_cnt=3. Reports come out in order 3 (multi=1), 9 (multi=1), 30 (multi=0), each separated by >= 1 idle cycle.
- Round-robin wrap: rr_ptr=31 after acking JID 30; bits 31 and 0 both pending -> JID 31 granted first, then JID 0.
- Stall and re-trigger:
  - Hold rpt_ack=0 for 10 cycles -> rpt_vld, rpt_jid and rpt_multi stay stable.
  - Drop bit 5 and raise it again while its report is presented, then ack -> bit 5 is reported a second time.
- Enable and saturation:
  - en=0: a rise on bit 2 -> no pend, no count.
  - en=1, with err_cnt forced to 254 and 4 bits rising together -> err_cnt=255 and stays there.
  - csr_cnt_clr coinciding with a rise -> err_cnt=0.
- Async reset mid-PRESENT: assert rst_l=0 between clock edges -> rpt_vld, pend_any and err_cnt go to 0 immediately. After release, bits still held high are re-detected as rises.
